jk_bank_ctrl: RTL and testbench

Arbitrated command controller for a bank of WIDTH single-bit JK flip-flops, one J/K pair per bit.
- Up to NUM_REQ requesters issue HOLD/CLR/SET/TOG commands to one addressed bit.
- The block grants one requester at a time in round-robin order and drives that bit's j/k for exactly one clock.
- It then reads the bit's q back, checks it against the expected result and returns a response.
- Sits between control logic and the flop bank; the bank sees only j_out/k_out; q_in is the bank's q vector.

---
 rtl/jk_bank_pkg.sv | 28 ++
 rtl/jk_rr_arbiter.sv | 40 ++++
 rtl/jk_bank_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_jk_bank_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_bank_pkg.sv
// Shared definitions for jk_bank_ctrl: command codes, FSM state encodings and the
// expected-result helper used to validate the bank's q read-back.
package jk_bank_pkg;

    typedef logic [1:0] jk_cmd_t;

    localparam jk_cmd_t CMD_HOLD = 2'b00;
    localparam jk_cmd_t CMD_CLR  = 2'b01;
    localparam jk_cmd_t CMD_SET  = 2'b10;
    localparam jk_cmd_t CMD_TOG  = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    // Value a healthy JK flop holds after one clock of cmd, given its prior value snap.
    function automatic logic jk_expected(input jk_cmd_t cmd, input logic snap);
        logic res;
        case (cmd)
            CMD_HOLD: res = snap;
            CMD_CLR:  res = 1'b0;
            CMD_SET:  res = 1'b1;
            default:  res = ~snap;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/jk_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid requester at or after rr_ptr_i,
// wrapping, plus the encoded id of the winner.
module jk_rr_arbiter
    import jk_bank_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IW      = 2
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic               en_i,
    input  logic [IW-1:0]      rr_ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IW-1:0]      gnt_id_o,
    output logic               gnt_valid_o
);

    always_comb begin
        gnt_o       = '0;
        gnt_id_o    = '0;
        gnt_valid_o = 1'b0;
        if (en_i) begin
            // Upper pass covers requesters at or after the pointer, lower pass the wrap.
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!gnt_valid_o && req_valid_i[i] && (i >= 32'(rr_ptr_i))) begin
                    gnt_o[i]    = 1'b1;
                    gnt_id_o    = IW'(i);
                    gnt_valid_o = 1'b1;
                end
            end
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!gnt_valid_o && req_valid_i[i]) begin
                    gnt_o[i]    = 1'b1;
                    gnt_id_o    = IW'(i);
                    gnt_valid_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/jk_bank_ctrl.sv
// Arbitrated command controller for a bank of JK flops: drives one bit's j/k for one clock,
// reads q back and reports it. Optional counters are enabled by JK_BANK_CTRL_ERR_CNT_EN.
module jk_bank_ctrl
    import jk_bank_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8,
    localparam int unsigned AW     = $clog2(WIDTH),
    localparam int unsigned IW     = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [2*NUM_REQ-1:0]  req_cmd,
    input  logic [AW*NUM_REQ-1:0] req_addr,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [WIDTH-1:0]      j_out,
    output logic [WIDTH-1:0]      k_out,
    input  logic [WIDTH-1:0]      q_in,
    output logic                  rsp_valid,
    output logic [IW-1:0]         rsp_id,
    output logic                  rsp_q,
    output logic                  rsp_err,
    output logic                  busy
`ifdef JK_BANK_CTRL_ERR_CNT_EN
    ,
    output logic [15:0]           cmd_count,
    output logic [15:0]           err_count
`endif
);

    localparam int unsigned AS = 1 << AW;

    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    id_q, id_d;
    logic [IW-1:0]    rr_q, rr_d;
    jk_cmd_t          cmd_q, cmd_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             snap_q, snap_d;
    logic             oor_q, oor_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IW-1:0]    rsp_id_q, rsp_id_d;
    logic             rsp_q_q, rsp_q_d;
    logic             rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]      gnt_id;
    logic               gnt_valid;
    logic               idle;

    jk_cmd_t          sel_cmd;
    logic [AW-1:0]    sel_addr;
    logic [WIDTH-1:0] sel_mask;
    logic             sel_in_range;
    logic [AS-1:0]    q_ext;
    logic             chk_bit;

    assign idle = (state_q == ST_IDLE);

    jk_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_arb (
        .req_valid_i (req_valid),
        .en_i        (idle),
        .rr_ptr_i    (rr_q),
        .gnt_o       (gnt),
        .gnt_id_o    (gnt_id),
        .gnt_valid_o (gnt_valid)
    );

    always_comb begin
        sel_cmd  = CMD_HOLD;
        sel_addr = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_cmd  = req_cmd[2*i +: 2];
                sel_addr = req_addr[AW*i +: AW];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sel_mask[i] = (32'(sel_addr) == i);
        end
    end

    // Pad q to the whole address space so an out-of-range address reads back 0.
    always_comb begin
        q_ext            = '0;
        q_ext[WIDTH-1:0] = q_in;
    end

    assign sel_in_range = (32'(sel_addr) < WIDTH);
    assign chk_bit      = q_ext[addr_q];

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        rr_d        = rr_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        snap_d      = snap_q;
        oor_d       = oor_q;
        j_d         = '0;
        k_d         = '0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_q_d     = rsp_q_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    id_d   = gnt_id;
                    cmd_d  = sel_cmd;
                    addr_d = sel_addr;
                    snap_d = q_ext[sel_addr];
                    oor_d  = !sel_in_range;
                    j_d    = sel_cmd[1] ? sel_mask : '0;
                    k_d    = sel_cmd[0] ? sel_mask : '0;
                    if (32'(gnt_id) == NUM_REQ - 1) begin
                        rr_d = '0;
                    end else begin
                        rr_d = gnt_id + IW'(1);
                    end
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                rsp_q_d     = chk_bit;
                rsp_err_d   = oor_q | (chk_bit != jk_expected(cmd_q, snap_q));
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            id_q        <= '0;
            rr_q        <= '0;
            cmd_q       <= CMD_HOLD;
            addr_q      <= '0;
            snap_q      <= 1'b0;
            oor_q       <= 1'b0;
            j_q         <= '0;
            k_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_q_q     <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            rr_q        <= rr_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            snap_q      <= snap_d;
            oor_q       <= oor_d;
            j_q         <= j_d;
            k_q         <= k_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_q_q     <= rsp_q_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef JK_BANK_CTRL_ERR_CNT_EN
    logic [15:0] cmd_cnt_q, err_cnt_q;

    // Counters advance on the same edge that launches the response.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_cnt_q <= '0;
            err_cnt_q <= '0;
        end else if (state_q == ST_CHECK) begin
            if (cmd_cnt_q != 16'hFFFF) begin
                cmd_cnt_q <= cmd_cnt_q + 16'd1;
            end
            if (rsp_err_d && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign cmd_count = cmd_cnt_q;
    assign err_count = err_cnt_q;
`endif

    assign req_ready = gnt;
    assign j_out     = j_q;
    assign k_out     = k_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_q     = rsp_q_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = !idle;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Self-checking bench for jk_bank_ctrl: a JK bank model with optional stuck-at bit and a
// transaction-level reference (grant order, response timeline, expected q).
module tb_jk_bank_ctrl;

    localparam int NR = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [7:0]  req_cmd;
    logic [11:0] req_addr;
    logic [3:0]  req_ready;
    logic [7:0]  j_out, k_out, q_in;
    logic        rsp_valid, rsp_q, rsp_err, busy;
    logic [1:0]  rsp_id;

    logic [3:0]  v6;
    logic [7:0]  c6;
    logic [11:0] a6;
    logic [3:0]  r6;
    logic [5:0]  j6, k6, q6;
    logic        rv6, rq6, re6, b6;
    logic [1:0]  rid6;

`ifdef JK_BANK_CTRL_ERR_CNT_EN
    logic [15:0] cmd_count, err_count, cmd_count6, err_count6;
`endif

    always #5 clk = ~clk;

    jk_bank_ctrl #(.NUM_REQ(4), .WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_cmd   (req_cmd),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .j_out     (j_out),
        .k_out     (k_out),
        .q_in      (q_in),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_q     (rsp_q),
        .rsp_err   (rsp_err),
        .busy      (busy)
`ifdef JK_BANK_CTRL_ERR_CNT_EN
        ,
        .cmd_count (cmd_count),
        .err_count (err_count)
`endif
    );

    jk_bank_ctrl #(.NUM_REQ(4), .WIDTH(6)) dut6 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (v6),
        .req_cmd   (c6),
        .req_addr  (a6),
        .req_ready (r6),
        .j_out     (j6),
        .k_out     (k6),
        .q_in      (q6),
        .rsp_valid (rv6),
        .rsp_id    (rid6),
        .rsp_q     (rq6),
        .rsp_err   (re6),
        .busy      (b6)
`ifdef JK_BANK_CTRL_ERR_CNT_EN
        ,
        .cmd_count (cmd_count6),
        .err_count (err_count6)
`endif
    );

    // Behavioural JK bank; bit 7 can be forced stuck-at-0.
    logic [7:0] bank, load_val;
    logic       load_en, stuck;
    logic [7:0] stuck_mask;
    assign stuck_mask = {stuck, 7'b0};
    assign q_in = bank;

    always @(posedge clk) begin
        if (load_en) bank <= load_val & ~stuck_mask;
        else         bank <= ((j_out & ~bank) | (~k_out & bank)) & ~stuck_mask;
    end

    typedef struct {
        int   due;
        int   id;
        logic q;
        logic err;
    } rsp_t;

    rsp_t pend[$];
    int   cyc, next_free, ptr, drv_cyc, m_cmd, m_err;
    logic [7:0] exp_j, exp_k;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic result_of(input logic [1:0] c, input logic snap);
        if (c == 2'b00) return snap;
        if (c == 2'b01) return 1'b0;
        if (c == 2'b10) return 1'b1;
        return ~snap;
    endfunction

    task automatic set_req(input int i, input logic v, input logic [1:0] c, input logic [2:0] a);
        req_valid[i]      = v;
        req_cmd[2*i +: 2] = c;
        req_addr[3*i +: 3] = a;
    endtask

    // One clock: check all outputs against the model, then advance model and clock.
    task automatic step();
        logic [3:0] eg;
        int         eid;
        logic [1:0] c;
        logic [2:0] a;
        logic       snap, res, act;
        rsp_t       r;
        #1;
        eg  = '0;
        eid = -1;
        if (cyc >= next_free) begin
            for (int o = 0; o < NR; o++) begin
                int i;
                i = (ptr + o) % NR;
                if (eid < 0 && req_valid[i]) begin
                    eid   = i;
                    eg[i] = 1'b1;
                end
            end
        end
        chk("req_ready", 32'(req_ready), 32'(eg));
        chk("busy", 32'(busy), 32'(cyc < next_free));
        chk("j_out", 32'(j_out), (cyc == drv_cyc) ? 32'(exp_j) : 32'd0);
        chk("k_out", 32'(k_out), (cyc == drv_cyc) ? 32'(exp_k) : 32'd0);
        if (pend.size() > 0 && pend[0].due == cyc) begin
            r = pend.pop_front();
            m_cmd++;
            if (r.err) m_err++;
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_id", 32'(rsp_id), 32'(r.id));
            chk("rsp_q", 32'(rsp_q), 32'(r.q));
            chk("rsp_err", 32'(rsp_err), 32'(r.err));
        end else begin
            chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
        end
`ifdef JK_BANK_CTRL_ERR_CNT_EN
        chk("cmd_count", 32'(cmd_count), 32'(m_cmd));
        chk("err_count", 32'(err_count), 32'(m_err));
`endif
        if (eid >= 0) begin
            c = req_cmd[2*eid +: 2];
            a = req_addr[3*eid +: 3];
            snap = bank[a];
            res  = result_of(c, snap);
            act  = (stuck && a == 3'd7) ? 1'b0 : res;
            r.due = cyc + 3;
            r.id  = eid;
            r.q   = act;
            r.err = (act != res);
            pend.push_back(r);
            drv_cyc = cyc + 1;
            exp_j = '0;
            exp_k = '0;
            if (c[1]) exp_j[a] = 1'b1;
            if (c[0]) exp_k[a] = 1'b1;
            next_free = cyc + 3;
            ptr = (eid + 1) % NR;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        reset = 1'b0;
        next_free = cyc;
        ptr = 0;
        drv_cyc = -1;
        m_cmd = 0;
        m_err = 0;
        pend.delete();
        #1;
        chk("rst_j_out", 32'(j_out), 32'd0);
        chk("rst_k_out", 32'(k_out), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_q", 32'(rsp_q), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_busy6", 32'(b6), 32'd0);
    endtask

    task automatic preload(input logic [7:0] v);
        load_val = v;
        load_en  = 1'b1;
        step();
        load_en  = 1'b0;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 2'b00, 3'd0);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0; req_cmd = '0; req_addr = '0;
        v6 = '0; c6 = '0; a6 = '0; q6 = '0;
        stuck = 1'b0; load_en = 1'b1; load_val = '0;
        cyc = 0; next_free = 0; ptr = 0; drv_cyc = -1; m_cmd = 0; m_err = 0;
        exp_j = '0; exp_k = '0;
        @(negedge clk);
        do_reset();
        load_en = 1'b0;

        // SET addr 3 from requester 0 on a cleared bank.
        preload(8'h00);
        set_req(0, 1'b1, 2'b10, 3'd3);
        step();
        clear_reqs();
        repeat (4) step();

        // Two back-to-back TOGs on addr 5 (initially 1) from requester 2.
        preload(8'h20);
        set_req(2, 1'b1, 2'b11, 3'd5);
        repeat (4) step();
        clear_reqs();
        repeat (4) step();

        // All requesters hammer HOLD on addr 0: round-robin 0,1,2,3,0,...
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 2'b00, 3'd0);
        repeat (16) step();
        clear_reqs();
        repeat (3) step();

        // Stuck-at-0 on bit 7, SET addr 7 must flag an error.
        do_reset();
        stuck = 1'b1;
        preload(8'h00);
        set_req(0, 1'b1, 2'b10, 3'd7);
        step();
        clear_reqs();
        repeat (4) step();
`ifdef JK_BANK_CTRL_ERR_CNT_EN
        chk("stuck_cmd_count", 32'(cmd_count), 32'd1);
        chk("stuck_err_count", 32'(err_count), 32'd1);
`endif
        stuck = 1'b0;
        preload(8'h00);

        // Reset while driving a CLR: command dropped, pointer back to 0.
        preload(8'hFF);
        set_req(2, 1'b1, 2'b01, 3'd2);
        step();
        clear_reqs();
        do_reset();
        repeat (3) step();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 2'b11, 3'(i));
        step();
        clear_reqs();
        repeat (4) step();

        // Randomized traffic.
        for (int n = 0; n < 240; n++) begin
            for (int i = 0; i < NR; i++) begin
                set_req(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                        3'($urandom_range(0, 7)));
            end
            step();
        end
        clear_reqs();
        repeat (4) step();

        // WIDTH=6 instance: requester 1 SET to out-of-range addr 7.
        v6[1] = 1'b1;
        c6[3:2] = 2'b10;
        a6[5:3] = 3'd7;
        #1;
        chk("w6_ready", 32'(r6), 32'h2);
        chk("w6_busy_idle", 32'(b6), 32'd0);
        step();
        v6 = '0;
        #1;
        chk("w6_j_drive", 32'(j6), 32'd0);
        chk("w6_k_drive", 32'(k6), 32'd0);
        chk("w6_busy_drive", 32'(b6), 32'd1);
        step();
        #1;
        chk("w6_j_check", 32'(j6), 32'd0);
        chk("w6_rsp_valid_early", 32'(rv6), 32'd0);
        step();
        #1;
        chk("w6_rsp_valid", 32'(rv6), 32'd1);
        chk("w6_rsp_id", 32'(rid6), 32'd1);
        chk("w6_rsp_q", 32'(rq6), 32'd0);
        chk("w6_rsp_err", 32'(re6), 32'd1);
        chk("w6_busy_done", 32'(b6), 32'd0);
        step();
        #1;
        chk("w6_rsp_valid_drop", 32'(rv6), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
